// File: rtl/zbs_bitpos_unit.sv
// Iterative Zbs single-bit unit (BSET/BCLR/BINV/BEXT): shifts a one-hot mask up to the bit
// index over several cycles, then applies it to rs1. Optional `ZBS_FLUSH_EN adds a flush input.
module zbs_bitpos_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef ZBS_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [4:0]      shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned IdxW = $clog2(XLEN);

    localparam logic [1:0] OpBset = 2'b00;
    localparam logic [1:0] OpBclr = 2'b01;
    localparam logic [1:0] OpBinv = 2'b10;
    localparam logic [1:0] OpBext = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   mask_q, mask_d;
    logic [IdxW-1:0]   remaining_q, remaining_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [IdxW-1:0]   shamt_idx;
    logic              flush_req;

    // Only the low index bits are meaningful, so the 1 never leaves the word.
    assign shamt_idx = IdxW'(shamt);

`ifdef ZBS_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    function automatic logic [XLEN-1:0] apply_op(input logic [1:0]      f_op,
                                                 input logic [XLEN-1:0] f_src,
                                                 input logic [XLEN-1:0] f_mask);
        logic [XLEN-1:0] res;
        res = '0;
        unique case (f_op)
            OpBset: res = f_src | f_mask;
            OpBclr: res = f_src & ~f_mask;
            OpBinv: res = f_src ^ f_mask;
            OpBext: res = {{(XLEN-1){1'b0}}, |(f_src & f_mask)};
            default: res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        mask_d      = mask_q;
        remaining_d = remaining_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush_req) begin
                    op_d        = op;
                    rs1_d       = rs1;
                    mask_d      = XLEN'(1);
                    remaining_d = shamt_idx;
                    if (shamt_idx == '0) begin
                        // Index 0 needs no shifting: the result is ready right away.
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        result_d    = apply_op(op, rs1, XLEN'(1));
                    end else begin
                        state_d = StShift;
                    end
                end
            end

            StShift: begin
                if (32'(remaining_q) >= STEP) begin
                    mask_d      = mask_q << STEP;
                    remaining_d = remaining_q - IdxW'(STEP);
                end else begin
                    mask_d      = mask_q << 1;
                    remaining_d = remaining_q - IdxW'(1);
                end
                if (remaining_d == '0) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    result_d    = apply_op(op_q, rs1_q, mask_d);
                end
            end

            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase

        // Flush wins over every handshake; the result register is left untouched.
        if (flush_req) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            rs1_q       <= '0;
            mask_q      <= XLEN'(1);
            remaining_q <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            mask_q      <= mask_d;
            remaining_q <= remaining_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_zbs_bitpos_unit.sv
// Bench for zbs_bitpos_unit: two instances (STEP=1 and STEP=4) share stimulus and are checked
// against an arithmetic reference of Zbs semantics and the expected latency.
module tb_zbs_bitpos_unit;

    localparam int unsigned S1 = 1;
    localparam int unsigned S4 = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [4:0]  shamt;
    logic        out_ready;
`ifdef ZBS_FLUSH_EN
    logic        flush;
`endif

    logic        rdy1, ov1, busy1;
    logic [31:0] res1;
    logic        rdy4, ov4, busy4;
    logic [31:0] res4;

    int vectors;
    int miscompares;

    zbs_bitpos_unit #(.XLEN(32), .STEP(S1)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ZBS_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (rdy1),
        .op        (op),
        .rs1       (rs1),
        .shamt     (shamt),
        .out_valid (ov1),
        .out_ready (out_ready),
        .result    (res1),
        .busy      (busy1)
    );

    zbs_bitpos_unit #(.XLEN(32), .STEP(S4)) u_s4 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ZBS_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (rdy4),
        .op        (op),
        .rs1       (rs1),
        .shamt     (shamt),
        .out_valid (ov4),
        .out_ready (out_ready),
        .result    (res4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input int k);
        logic [31:0] bitv;
        bitv = 32'd1 << k;
        case (o)
            2'd0:    return a | bitv;
            2'd1:    return a & ~bitv;
            2'd2:    return a ^ bitv;
            default: return (a >> k) & 32'd1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy1"}, {31'b0, rdy1}, 32'd1);
        check({tag, "_rdy4"}, {31'b0, rdy4}, 32'd1);
        check({tag, "_ov1"}, {31'b0, ov1}, 32'd0);
        check({tag, "_ov4"}, {31'b0, ov4}, 32'd0);
        check({tag, "_busy1"}, {31'b0, busy1}, 32'd0);
    endtask

    // One request to both instances with out_ready high; latency and result checked per step.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input int k);
        logic [31:0] exp;
        logic seen1, seen4;
        exp = ref_result(o, a, k);
        op = o; rs1 = a; shamt = 5'(k); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 2'($urandom); rs1 = $urandom; shamt = 5'($urandom);
        seen1 = 1'b0; seen4 = 1'b0;
        for (int c = 1; c <= 64 && !(seen1 && seen4); c++) begin
            if (!seen1 && ov1) begin
                seen1 = 1'b1;
                check("lat_s1", 32'(c), 32'(k / S1 + k % S1 + 1));
                check("res_s1", res1, exp);
                check("rdy_done_s1", {31'b0, rdy1}, 32'd0);
            end
            if (!seen4 && ov4) begin
                seen4 = 1'b1;
                check("lat_s4", 32'(c), 32'(k / S4 + k % S4 + 1));
                check("res_s4", res4, exp);
            end
            if (!(seen1 && seen4)) tick();
        end
        check("done_s1", {31'b0, seen1}, 32'd1);
        check("done_s4", {31'b0, seen4}, 32'd1);
        tick();
        check_idle("after_op");
    endtask

    initial begin
        logic [31:0] held;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; rs1 = '0; shamt = '0; out_ready = 1'b1;
`ifdef ZBS_FLUSH_EN
        flush = 1'b0;
`endif
        tick(); tick();
        rst_n = 1'b1;
        check_idle("reset");
        check("reset_res1", res1, 32'd0);
        check("reset_res4", res4, 32'd0);

        // Directed cases from the data sheet.
        run_op(2'd0, 32'h0000_0000, 5);
        run_op(2'd1, 32'hFFFF_FFFF, 0);
        run_op(2'd3, 32'h8000_0000, 31);
        run_op(2'd3, 32'h7FFF_FFFF, 31);
        run_op(2'd2, 32'h1234_5678, 4);

        // Backpressure: result must hold while out_ready is low; in_valid meanwhile is ignored.
        op = 2'd2; rs1 = 32'h0000_00FF; shamt = 5'd3; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        rs1 = 32'hDEAD_BEEF; op = 2'd0; shamt = 5'd1;
        for (int c = 1; c <= 20 && !(ov1 && ov4); c++) tick();
        check("hold_ov1", {31'b0, ov1}, 32'd1);
        check("hold_ov4", {31'b0, ov4}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_res1", res1, 32'h0000_00F7);
            check("hold_res4", res4, 32'h0000_00F7);
            check("hold_rdy1", {31'b0, rdy1}, 32'd0);
            check("hold_ovh", {31'b0, ov1 & ov4}, 32'd1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_idle("hold_release");

        // Reset in the middle of a long shift discards the operation.
        op = 2'd0; rs1 = 32'h0; shamt = 5'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("mid_busy1", {31'b0, busy1}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("mid_reset");
        check("mid_res1", res1, 32'd0);
        check("mid_res4", res4, 32'd0);
        run_op(2'd2, 32'hA5A5_0F0F, 20);

`ifdef ZBS_FLUSH_EN
        // Flush in DONE drops out_valid but keeps the result; a flushed offer in IDLE is refused.
        op = 2'd0; rs1 = 32'h0; shamt = 5'd2; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 20 && !(ov1 && ov4); c++) tick();
        held = res1;
        check("fl_res_pre", held, 32'h0000_0004);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("flush_done");
        check("fl_res_keep", res1, held);
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_idle");
        run_op(2'd1, 32'hFFFF_FFFF, 9);
`else
        held = '0;
`endif

        // Randomised traffic against the reference.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), $urandom, int'($urandom_range(31, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
